if_prefetch: RTL and testbench
==============================

# if_prefetch

Instruction fetch and prefetch stage directly upstream of the MIPS datapath decode stage. It generates sequential fetch addresses to a synchronous instruction memory with fixed 1-cycle read latency, buffers returned words with their PCs in a small FIFO, and hands them to decode over a valid/ready handshake. A redirect from the datapath (branch, jump, exception) flushes the buffer, kills any in-flight read and restarts fetch at the new PC.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2.
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_en  out  1  read strobe; data returns on imem_rdata one cycle later.
- imem_addr  out  32  word-aligned read address; bits [1:0] always 0.
- imem_rdata  in  32  read data, valid the cycle after imem_en.
- inst_valid  out  1  FIFO head holds an instruction.
- inst  out  32  instruction word at the FIFO head.
- inst_pc  out  32  PC of inst.
- inst_ready  in  1  decode accepts the head this cycle.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored and treated as 0.

## Operation
- State: fetch_pc (32b), pending (1b in-flight flag), pending_pc (32b), kill (1b), FIFO storage of {inst, pc} with rd/wr pointers (log2 DEPTH bits, natural wrap) and count (log2 DEPTH + 1 bits).
- Issue: imem_en = !reset && !redirect_valid && (count + pending < DEPTH). imem_addr = fetch_pc. On issue: fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0), pending <= 1, pending_pc <= fetch_pc, kill <= 0; otherwise pending <= 0.
- Credit check uses the registered count; a pop in the same cycle does not free a slot until the next cycle, so the FIFO never overflows.
- Return: when pending && !kill && !redirect_valid, write {imem_rdata, pending_pc} at wr_ptr.
- Pop: the transfer occurs when inst_valid && inst_ready. Advance rd_ptr. Simultaneous push and pop leave count unchanged.
- Redirect: fetch_pc <= {redirect_pc[31:2], 2'b00}, and both pointers and count are cleared. A read returning in the redirect cycle is dropped. If a read was issued in the redirect cycle, it is impossible because imem_en is forced low. A pop handshake in the redirect cycle still counts as consumed by decode. The first post-redirect fetch issues the following cycle.
- kill is set by redirect while pending, for robustness. Its reset value is 0.
- inst_valid = (count != 0). inst and inst_pc are driven from the entry at rd_ptr.

## Timing
- Reset (asynchronous): fetch_pc = RESET_PC, pending = 0, kill = 0, count = 0, pointers = 0, storage = 0. Outputs during reset: imem_en = 0, imem_addr = RESET_PC, inst_valid = 0, inst = 0, inst_pc = 0.
- After the reset release edge, cycle 0: imem_en = 1, addr RESET_PC. Cycle 1: rdata is captured into the FIFO. Cycle 2: inst_valid = 1. Fetch-to-valid latency is 2 cycles.
- Redirect in cycle N: cycle N+1 issues at redirect_pc, and inst_valid for it appears in N+3. inst_valid = 0 in N+1 and N+2.
- With inst_ready held at 1, sustained throughput is one instruction per cycle after the 2-cycle fill.
- With inst_ready held at 0, issue stops once count + pending = DEPTH. The FIFO holds exactly DEPTH entries, and no write is lost.
- Reset asserted mid-operation clears everything immediately. In-flight data is never written.

## Test plan
- Reset release, inst_ready = 1 -> imem_addr sequence BFC00000, BFC00004, BFC00008, and so on. The first inst_valid is 2 cycles after the first imem_en, and inst_pc matches each word's address.
- inst_ready = 0 for 10 cycles -> exactly 4 imem_en pulses and count = 4. Release -> 4 pops in order with no duplicates or gaps, then streaming resumes.
- FIFO holding 3 entries plus one pending read, then redirect_valid with redirect_pc = 0x8000_0013 -> the pending data is dropped and inst_valid = 0 for 2 cycles. The next imem_addr is 0x8000_0010, and the first delivered inst_pc is 0x8000_0010.
- Redirect in the same cycle as a pop handshake -> the popped entry counts as consumed, and no stale entry appears afterward.
- RESET_PC = 0xFFFF_FFF8 -> addresses FFFFFFF8, FFFFFFFC, 00000000.
- Reset asserted asynchronously while count = 2 and a read is pending -> inst_valid and imem_en drop immediately. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_prefetch.sv
`default_nettype none
// ============================================================================
// if_prefetch : sequential instruction fetch into a 1-cycle imem, buffered in
//               a DEPTH-entry {inst, pc} FIFO and handed to decode (valid/ready)
// Revision    : 1.0
// ============================================================================
module if_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        imem_en_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW+1:0] C_DEPTH = (AW+2)'(DEPTH);

  logic [31:0]   fetch_pc_q;
  logic          pending_q;
  logic [31:0]   pending_pc_q;
  logic          kill_q;
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;

  logic w_credit;
  logic w_issue;
  logic w_push;
  logic w_pop;
  logic w_unused;

  // Credit counts the in-flight read too, so a full FIFO never has a word arriving.
  assign w_credit = ({1'b0, count_q} + {{(AW+1){1'b0}}, pending_q}) < C_DEPTH;
  assign w_issue  = !reset_i && !redirect_valid_i && w_credit;
  assign w_push   = pending_q && !kill_q && !redirect_valid_i;
  assign w_pop    = inst_valid_o && inst_ready_i;
  assign w_unused = ^redirect_pc_i[1:0];

  assign imem_en_o    = w_issue;
  assign imem_addr_o  = fetch_pc_q;
  assign inst_valid_o = (count_q != '0);
  assign inst_o       = inst_mem_q[rd_ptr_q];
  assign inst_pc_o    = pc_mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fetch_pc_q   <= RESET_PC;
      pending_q    <= 1'b0;
      pending_pc_q <= '0;
      kill_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      pending_q <= w_issue;
      if (w_issue) begin
        fetch_pc_q   <= fetch_pc_q + 32'd4;
        pending_pc_q <= fetch_pc_q;
        kill_q       <= 1'b0;
      end
      if (redirect_valid_i) begin
        fetch_pc_q <= {redirect_pc_i[31:2], 2'b00};
        if (pending_q) kill_q <= 1'b1;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
      end else begin
        if (w_push) begin
          inst_mem_q[wr_ptr_q] <= imem_rdata_i;
          pc_mem_q[wr_ptr_q]   <= pending_pc_q;
          wr_ptr_q             <= wr_ptr_q + 1'b1;
        end
        if (w_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({w_push, w_pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch.sv
`default_nettype none
// ============================================================================
// tb_if_prefetch : directed self-checking bench for if_prefetch
// Revision       : 1.0
// ============================================================================
module tb_if_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, valid, ready, redir;
  logic [31:0] addr, rdata, inst, ipc, rpc;
  logic        en2, valid2;
  logic [31:0] addr2, rdata2, inst2, ipc2;

  int tests_run = 0;
  int failed    = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_1E0F;
  endfunction

  // 1-cycle synchronous instruction memories
  always @(posedge clk) if (en)  rdata  <= word(addr);
  always @(posedge clk) if (en2) rdata2 <= word(addr2);

  if_prefetch #(.DEPTH(4), .RESET_PC(32'hBFC0_0000)) dut (
    .clk_i(clk), .reset_i(rst),
    .imem_en_o(en), .imem_addr_o(addr), .imem_rdata_i(rdata),
    .inst_valid_o(valid), .inst_o(inst), .inst_pc_o(ipc), .inst_ready_i(ready),
    .redirect_valid_i(redir), .redirect_pc_i(rpc)
  );

  if_prefetch #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk_i(clk), .reset_i(rst),
    .imem_en_o(en2), .imem_addr_o(addr2), .imem_rdata_i(rdata2),
    .inst_valid_o(valid2), .inst_o(inst2), .inst_pc_o(ipc2), .inst_ready_i(1'b1),
    .redirect_valid_i(1'b0), .redirect_pc_i(32'h0)
  );

  task automatic step();
    @(negedge clk); #1;
  endtask

  // Leaves the bench just after the reset-release point (cycle 0 sample).
  task automatic apply_reset(input logic rdy);
    @(negedge clk); rst = 1'b1; redir = 1'b0; ready = rdy;
    @(negedge clk); rst = 1'b0; #1;
  endtask

  task automatic test_reset();
    step();
    tests_run++; if (en !== 1'b0) begin failed++; $display("FAIL reset_en got %0b want 0", en); end
    tests_run++; if (addr !== 32'hBFC0_0000) begin failed++; $display("FAIL reset_addr got %08h want bfc00000", addr); end
    tests_run++; if (valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %0b want 0", valid); end
    tests_run++; if (inst !== 32'h0) begin failed++; $display("FAIL reset_inst got %08h want 0", inst); end
    tests_run++; if (ipc !== 32'h0) begin failed++; $display("FAIL reset_pc got %08h want 0", ipc); end
    tests_run++; if (addr2 !== 32'hFFFF_FFF8) begin failed++; $display("FAIL reset_addr2 got %08h want fffffff8", addr2); end
  endtask

  task automatic test_stream();
    logic [31:0] ea, ep;
    apply_reset(1'b1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      ea = 32'hBFC0_0000 + 32'(4 * k);
      tests_run++; if (en !== 1'b1) begin failed++; $display("FAIL stream_en[%0d] got %0b want 1", k, en); end
      tests_run++; if (addr !== ea) begin failed++; $display("FAIL stream_addr[%0d] got %08h want %08h", k, addr, ea); end
      tests_run++; if (valid !== (k >= 2)) begin failed++; $display("FAIL stream_valid[%0d] got %0b want %0b", k, valid, k >= 2); end
      if (k >= 2) begin
        ep = 32'hBFC0_0000 + 32'(4 * (k - 2));
        tests_run++; if (ipc !== ep) begin failed++; $display("FAIL stream_pc[%0d] got %08h want %08h", k, ipc, ep); end
        tests_run++; if (inst !== word(ep)) begin failed++; $display("FAIL stream_inst[%0d] got %08h want %08h", k, inst, word(ep)); end
      end
    end
  endtask

  task automatic test_backpressure();
    int pulses;
    logic [31:0] ep;
    pulses = 0;
    apply_reset(1'b0);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      if (en === 1'b1) pulses++;
    end
    tests_run++; if (pulses != 4) begin failed++; $display("FAIL bp_pulses got %0d want 4", pulses); end
    tests_run++; if (en !== 1'b0) begin failed++; $display("FAIL bp_en_full got %0b want 0", en); end
    ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      if (r > 0) step();
      ep = 32'hBFC0_0000 + 32'(4 * r);
      tests_run++; if (valid !== 1'b1) begin failed++; $display("FAIL bp_valid[%0d] got %0b want 1", r, valid); end
      tests_run++; if (ipc !== ep) begin failed++; $display("FAIL bp_pc[%0d] got %08h want %08h", r, ipc, ep); end
      tests_run++; if (inst !== word(ep)) begin failed++; $display("FAIL bp_inst[%0d] got %08h want %08h", r, inst, word(ep)); end
      if (r == 0) begin
        tests_run++; if (en !== 1'b0) begin failed++; $display("FAIL bp_en_r0 got %0b want 0", en); end
      end
      if (r == 1) begin
        tests_run++; if (en !== 1'b1 || addr !== 32'hBFC0_0010) begin failed++; $display("FAIL bp_resume got en=%0b addr=%08h want en=1 addr=bfc00010", en, addr); end
      end
    end
  endtask

  task automatic test_redirect();
    apply_reset(1'b0);
    for (int k = 1; k <= 4; k++) step();
    tests_run++; if (valid !== 1'b1 || en !== 1'b0) begin failed++; $display("FAIL rd_setup got valid=%0b en=%0b want valid=1 en=0", valid, en); end
    redir = 1'b1; rpc = 32'h8000_0013; #1;
    tests_run++; if (en !== 1'b0) begin failed++; $display("FAIL rd_en_n got %0b want 0", en); end
    @(negedge clk); redir = 1'b0; ready = 1'b1; #1;
    tests_run++; if (valid !== 1'b0) begin failed++; $display("FAIL rd_valid_n1 got %0b want 0", valid); end
    tests_run++; if (en !== 1'b1 || addr !== 32'h8000_0010) begin failed++; $display("FAIL rd_issue_n1 got en=%0b addr=%08h want en=1 addr=80000010", en, addr); end
    step();
    tests_run++; if (valid !== 1'b0) begin failed++; $display("FAIL rd_valid_n2 got %0b want 0", valid); end
    tests_run++; if (addr !== 32'h8000_0014) begin failed++; $display("FAIL rd_addr_n2 got %08h want 80000014", addr); end
    step();
    tests_run++; if (valid !== 1'b1 || ipc !== 32'h8000_0010) begin failed++; $display("FAIL rd_first_n3 got valid=%0b pc=%08h want valid=1 pc=80000010", valid, ipc); end
    tests_run++; if (inst !== word(32'h8000_0010)) begin failed++; $display("FAIL rd_inst_n3 got %08h want %08h", inst, word(32'h8000_0010)); end
    step();
    tests_run++; if (ipc !== 32'h8000_0014) begin failed++; $display("FAIL rd_pc_n4 got %08h want 80000014", ipc); end
  endtask

  task automatic test_redirect_pop();
    apply_reset(1'b1);
    for (int k = 1; k <= 4; k++) step();
    redir = 1'b1; rpc = 32'h0000_1000; #1;
    tests_run++; if (valid !== 1'b1) begin failed++; $display("FAIL rp_handshake got valid=%0b want 1", valid); end
    @(negedge clk); redir = 1'b0; #1;
    tests_run++; if (valid !== 1'b0) begin failed++; $display("FAIL rp_valid_n1 got %0b want 0", valid); end
    step();
    tests_run++; if (valid !== 1'b0) begin failed++; $display("FAIL rp_valid_n2 got %0b want 0", valid); end
    step();
    tests_run++; if (valid !== 1'b1 || ipc !== 32'h0000_1000) begin failed++; $display("FAIL rp_first_n3 got valid=%0b pc=%08h want valid=1 pc=00001000", valid, ipc); end
    step();
    tests_run++; if (ipc !== 32'h0000_1004) begin failed++; $display("FAIL rp_pc_n4 got %08h want 00001004", ipc); end
  endtask

  task automatic test_wrap();
    logic [31:0] ea, ep;
    apply_reset(1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      ea = 32'hFFFF_FFF8 + 32'(4 * k);
      tests_run++; if (addr2 !== ea) begin failed++; $display("FAIL wrap_addr[%0d] got %08h want %08h", k, addr2, ea); end
      if (k >= 2) begin
        ep = 32'hFFFF_FFF8 + 32'(4 * (k - 2));
        tests_run++; if (valid2 !== 1'b1 || ipc2 !== ep) begin failed++; $display("FAIL wrap_pc[%0d] got valid=%0b pc=%08h want %08h", k, valid2, ipc2, ep); end
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset(1'b0);
    for (int k = 1; k <= 3; k++) step();
    tests_run++; if (valid !== 1'b1 || en !== 1'b1) begin failed++; $display("FAIL ar_setup got valid=%0b en=%0b want 1 1", valid, en); end
    #2 rst = 1'b1; #1;
    tests_run++; if (en !== 1'b0 || valid !== 1'b0) begin failed++; $display("FAIL ar_drop got en=%0b valid=%0b want 0 0", en, valid); end
    tests_run++; if (addr !== 32'hBFC0_0000 || ipc !== 32'h0) begin failed++; $display("FAIL ar_state got addr=%08h pc=%08h want bfc00000 0", addr, ipc); end
    @(negedge clk); rst = 1'b0; #1;
    tests_run++; if (en !== 1'b1 || addr !== 32'hBFC0_0000) begin failed++; $display("FAIL ar_restart got en=%0b addr=%08h want 1 bfc00000", en, addr); end
    step();
    tests_run++; if (valid !== 1'b0) begin failed++; $display("FAIL ar_valid_c1 got %0b want 0", valid); end
    step();
    tests_run++; if (valid !== 1'b1 || ipc !== 32'hBFC0_0000) begin failed++; $display("FAIL ar_first got valid=%0b pc=%08h want 1 bfc00000", valid, ipc); end
    step();
    tests_run++; if (ipc !== 32'hBFC0_0000) begin failed++; $display("FAIL ar_hold got %08h want bfc00000", ipc); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ready = 1'b1; redir = 1'b0; rpc = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
`default_nettype wire
